// File: rtl/hk_spi_responder.sv
// SPI mode-0 target: oversamples CSB/SCK/SDI in the core clock domain and turns
// command/address/data bytes into byte-wide housekeeping register strobes.
module hk_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 spi_csb,
    input  logic                 spi_sck,
    input  logic                 spi_sdi,
    output logic                 spi_sdo,
    output logic                 spi_sdo_oe,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [7:0]           reg_wdata,
    output logic                 reg_we,
    output logic                 reg_re,
    input  logic [7:0]           reg_rdata,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] csb_sync, sck_sync, sdi_sync;
    logic                   csb_prev, sck_prev, started, armed;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_in, out_shift;
    logic                   wr_mode, rd_mode, inc_pend;

    logic       csb_s, sdi_s, sck_rise, sck_fall, csb_fall, byte_done;
    logic [7:0] in_byte;

    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_sync[SYNC_STAGES-1] & ~sck_prev;
    assign sck_fall  = ~sck_sync[SYNC_STAGES-1] & sck_prev;
    assign csb_fall  = ~csb_s & csb_prev & armed;
    assign in_byte   = {shift_in[6:0], sdi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);

    // A transaction is only accepted once CSB has been genuinely seen high after
    // reset; the synchronizer's reset value of 1 must not count as that.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csb_sync <= '1;
            sck_sync <= '0;
            sdi_sync <= '0;
            csb_prev <= 1'b1;
            sck_prev <= 1'b0;
            started  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            csb_sync <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            csb_prev <= csb_s;
            sck_prev <= sck_sync[SYNC_STAGES-1];
            started  <= 1'b1;
            if (started && csb_sync[0])
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_in   <= '0;
            out_shift  <= '0;
            wr_mode    <= 1'b0;
            rd_mode    <= 1'b0;
            inc_pend   <= 1'b0;
            spi_sdo    <= 1'b0;
            spi_sdo_oe <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            inc_pend <= 1'b0;
            if (reg_re)
                out_shift <= reg_rdata;
            if (csb_s) begin
                state      <= IDLE;
                busy       <= 1'b0;
                spi_sdo_oe <= 1'b0;
                spi_sdo    <= 1'b0;
                bit_cnt    <= '0;
                wr_mode    <= 1'b0;
                rd_mode    <= 1'b0;
            end else if (csb_fall) begin
                state   <= CMD;
                busy    <= 1'b1;
                bit_cnt <= '0;
            end else if (state != IDLE) begin
                if (sck_rise) begin
                    shift_in <= in_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                // Increment runs one clk after the data byte so the write strobe
                // still targets the old address and the read prefetch the new one.
                if (inc_pend) begin
                    reg_addr <= reg_addr + ADDR_BITS'(1);
                    reg_re   <= rd_mode;
                end
                case (state)
                    CMD: if (byte_done) begin
                        case (in_byte)
                            8'h80:   begin wr_mode <= 1'b1; rd_mode <= 1'b0; state <= ADDR; end
                            8'h40:   begin wr_mode <= 1'b0; rd_mode <= 1'b1; state <= ADDR; end
                            8'hC0:   begin wr_mode <= 1'b1; rd_mode <= 1'b1; state <= ADDR; end
                            default: state <= IGNORE;
                        endcase
                    end
                    ADDR: if (byte_done) begin
                        reg_addr <= in_byte[ADDR_BITS-1:0];
                        reg_re   <= rd_mode;
                        state    <= DATA;
                    end
                    DATA: begin
                        if (byte_done) begin
                            if (wr_mode) begin
                                reg_wdata <= in_byte;
                                reg_we    <= 1'b1;
                            end
                            inc_pend <= 1'b1;
                        end
                        if (sck_fall && rd_mode) begin
                            spi_sdo   <= out_shift[7];
                            out_shift <= {out_shift[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
                spi_sdo_oe <= (state == DATA) && rd_mode;
            end
        end
    end

endmodule

// File: tb/tb_hk_spi_responder.sv
// Self-checking bench for hk_spi_responder: drives SPI transactions against a
// register-file environment and compares strobes/SDO with a transaction-level model.
module tb_hk_spi_responder;

    localparam int HALF = 8;   // clk cycles per SCK half period

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       spi_csb = 1'b1, spi_sck = 1'b0, spi_sdi = 1'b0;
    logic       spi_sdo, spi_sdo_oe, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    logic [7:0] regs [256];
    logic [7:0] mref [256];
    logic [7:0] tx_data[$], rx_bytes[$];
    logic [7:0] we_a[$], we_d[$], re_a[$];
    logic [7:0] exp_wa[$], exp_wd[$], exp_ra[$], exp_sdo[$];
    int         n_cmp = 0, n_bad = 0, overlap = 0;
    bit         oe_seen = 0;

    hk_spi_responder #(.SYNC_STAGES(2), .ADDR_BITS(8)) dut (
        .clk(clk), .resetn(resetn), .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    assign reg_rdata = regs[reg_addr];

    // Register-file environment and strobe logger, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn) begin
            if (reg_we) begin
                we_a.push_back(reg_addr);
                we_d.push_back(reg_wdata);
                regs[reg_addr] = reg_wdata;
            end
            if (reg_re) re_a.push_back(reg_addr);
            if (reg_we && reg_re) overlap++;
            if (spi_sdo_oe) oe_seen = 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nb; i++) begin
            spi_sdi = tx[7-i];
            wait_clk(HALF);
            rx[7-i] = spi_sdo;
            spi_sck = 1'b1;
            wait_clk(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic clear_logs();
        we_a.delete(); we_d.delete(); re_a.delete(); rx_bytes.delete();
        oe_seen = 0;
    endtask

    task automatic init_mem(input bit inv_addr);
        for (int i = 0; i < 256; i++) begin
            regs[i] = inv_addr ? 8'(i ^ 8'hFF) : 8'($urandom);
            mref[i] = regs[i];
        end
    endtask

    // Transaction-level expectation: which writes, reads and SDO bytes a stream produces.
    task automatic model_xact(input logic [7:0] cmd, input logic [7:0] addr, input int n);
        logic [7:0] a;
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); exp_sdo.delete();
        if (cmd == 8'h80 || cmd == 8'h40 || cmd == 8'hC0) begin
            for (int i = 0; i < n; i++) begin
                a = 8'((int'(addr) + i) % 256);
                if (cmd != 8'h80) exp_sdo.push_back(mref[a]);
                if (cmd != 8'h40) begin
                    exp_wa.push_back(a);
                    exp_wd.push_back(tx_data[i]);
                    mref[a] = tx_data[i];
                end
            end
            if (cmd != 8'h80)
                for (int i = 0; i <= n; i++) exp_ra.push_back(8'((int'(addr) + i) % 256));
        end
    endtask

    task automatic drive_xact(input logic [7:0] cmd, input logic [7:0] addr, input int n);
        logic [7:0] rx;
        clear_logs();
        spi_csb = 1'b0;
        wait_clk(HALF);
        spi_bits(cmd, 8, rx);
        spi_bits(addr, 8, rx);
        for (int i = 0; i < n; i++) begin
            spi_bits(tx_data[i], 8, rx);
            rx_bytes.push_back(rx);
        end
        wait_clk(HALF);
        spi_csb = 1'b1;
        wait_clk(4 * HALF);
    endtask

    task automatic run(input logic [7:0] cmd, input logic [7:0] addr, input int n);
        model_xact(cmd, addr, n);
        drive_xact(cmd, addr, n);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        wait_clk(3);
        n_cmp++;
        if ({spi_sdo, spi_sdo_oe, reg_we, reg_re, busy} !== 5'b0 || reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got sdo=%b oe=%b we=%b re=%b busy=%b addr=%h wdata=%h required all 0",
                     spi_sdo, spi_sdo_oe, reg_we, reg_re, busy, reg_addr, reg_wdata);
        end
        resetn = 1'b1;
        wait_clk(6);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_write();
        for (int t = 0; t < 4; t++) begin
            init_mem(0);
            tx_data.delete();
            if (t == 0) begin
                tx_data.push_back(8'hA5); tx_data.push_back(8'h3C);
                run(8'h80, 8'h10, 2);
            end else begin
                for (int i = 0; i < t + 1; i++) tx_data.push_back(8'($urandom));
                run(8'h80, 8'($urandom), t + 1);
            end
            n_cmp++;
            if (we_a.size() !== exp_wa.size() || re_a.size() !== 0) begin
                n_bad++;
                $display("FAIL write_count[%0d]: got we=%0d re=%0d required we=%0d re=0", t, we_a.size(), re_a.size(), exp_wa.size());
            end
            for (int i = 0; i < exp_wa.size() && i < we_a.size(); i++) begin
                n_cmp++;
                if (we_a[i] !== exp_wa[i] || we_d[i] !== exp_wd[i]) begin
                    n_bad++;
                    $display("FAIL write_strobe[%0d.%0d]: got (%h,%h) required (%h,%h)", t, i, we_a[i], we_d[i], exp_wa[i], exp_wd[i]);
                end
            end
            n_cmp++;
            if (oe_seen !== 1'b0) begin
                n_bad++;
                $display("FAIL write_sdo_oe[%0d]: got 1 required 0", t);
            end
        end
    endtask

    task automatic check_read(input string tag);
        n_cmp++;
        if (re_a.size() !== exp_ra.size() || rx_bytes.size() !== exp_sdo.size()) begin
            n_bad++;
            $display("FAIL %s_count: got re=%0d sdo=%0d required re=%0d sdo=%0d", tag, re_a.size(), rx_bytes.size(), exp_ra.size(), exp_sdo.size());
        end
        for (int i = 0; i < exp_ra.size() && i < re_a.size(); i++) begin
            n_cmp++;
            if (re_a[i] !== exp_ra[i]) begin
                n_bad++;
                $display("FAIL %s_re_addr[%0d]: got %h required %h", tag, i, re_a[i], exp_ra[i]);
            end
        end
        for (int i = 0; i < exp_sdo.size() && i < rx_bytes.size(); i++) begin
            n_cmp++;
            if (rx_bytes[i] !== exp_sdo[i]) begin
                n_bad++;
                $display("FAIL %s_sdo[%0d]: got %h required %h", tag, i, rx_bytes[i], exp_sdo[i]);
            end
        end
    endtask

    task automatic test_read();
        for (int t = 0; t < 3; t++) begin
            init_mem(t == 0);
            tx_data.delete();
            for (int i = 0; i < 3; i++) tx_data.push_back(8'($urandom));
            run(8'h40, (t == 0) ? 8'h20 : 8'($urandom), 3);
            check_read("read");
            n_cmp++;
            if (we_a.size() !== 0 || oe_seen !== 1'b1) begin
                n_bad++;
                $display("FAIL read_side[%0d]: got we=%0d oe_seen=%b required we=0 oe_seen=1", t, we_a.size(), oe_seen);
            end
        end
    endtask

    task automatic test_read_write();
        for (int t = 0; t < 3; t++) begin
            init_mem(0);
            tx_data.delete();
            if (t == 0) begin
                regs[5] = 8'h77; mref[5] = 8'h77;
                tx_data.push_back(8'h12);
                run(8'hC0, 8'h05, 1);
            end else begin
                for (int i = 0; i < 3; i++) tx_data.push_back(8'($urandom));
                run(8'hC0, 8'($urandom), 3);
            end
            check_read("rw");
            n_cmp++;
            if (we_a.size() !== exp_wa.size()) begin
                n_bad++;
                $display("FAIL rw_we_count[%0d]: got %0d required %0d", t, we_a.size(), exp_wa.size());
            end
            for (int i = 0; i < exp_wa.size() && i < we_a.size(); i++) begin
                n_cmp++;
                if (we_a[i] !== exp_wa[i] || we_d[i] !== exp_wd[i]) begin
                    n_bad++;
                    $display("FAIL rw_we[%0d.%0d]: got (%h,%h) required (%h,%h)", t, i, we_a[i], we_d[i], exp_wa[i], exp_wd[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        init_mem(0);
        tx_data.delete();
        tx_data.push_back(8'h01); tx_data.push_back(8'h02);
        run(8'h80, 8'hFF, 2);
        n_cmp++;
        if (we_a.size() !== 2) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d required 2", we_a.size());
        end else begin
            n_cmp++;
            if (we_a[0] !== 8'hFF || we_d[0] !== 8'h01 || we_a[1] !== 8'h00 || we_d[1] !== 8'h02) begin
                n_bad++;
                $display("FAIL wrap_writes: got (%h,%h),(%h,%h) required (ff,01),(00,02)", we_a[0], we_d[0], we_a[1], we_d[1]);
            end
        end
        n_cmp++;
        if (regs[8'hFF] !== mref[8'hFF] || regs[0] !== mref[0]) begin
            n_bad++;
            $display("FAIL wrap_regs: got %h,%h required %h,%h", regs[8'hFF], regs[0], mref[8'hFF], mref[0]);
        end
    endtask

    task automatic test_abort_illegal();
        logic [7:0] rx, cmd;
        clear_logs();
        spi_csb = 1'b0;
        wait_clk(HALF);
        spi_bits(8'h80, 8, rx);
        spi_bits(8'($urandom), 8, rx);
        spi_bits(8'($urandom), 5, rx);
        spi_csb = 1'b1;
        wait_clk(3);
        n_cmp++;
        if (busy !== 1'b0 || spi_sdo_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: got busy=%b oe=%b required 0 0", busy, spi_sdo_oe);
        end
        wait_clk(4 * HALF);
        n_cmp++;
        if (we_a.size() !== 0) begin
            n_bad++;
            $display("FAIL abort_no_we: got %0d writes required 0", we_a.size());
        end
        for (int t = 0; t < 3; t++) begin
            do cmd = 8'($urandom); while (cmd == 8'h80 || cmd == 8'h40 || cmd == 8'hC0);
            if (t == 0) cmd = 8'h33;
            tx_data.delete();
            for (int i = 0; i < 3; i++) tx_data.push_back(8'($urandom));
            run(cmd, 8'($urandom), 3);
            n_cmp++;
            if (we_a.size() + re_a.size() !== 0 || oe_seen !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_cmd_%h: got we=%0d re=%0d oe_seen=%b required 0 0 0", cmd, we_a.size(), re_a.size(), oe_seen);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        init_mem(1);
        clear_logs();
        spi_csb = 1'b0;
        wait_clk(HALF);
        spi_bits(8'h40, 8, rx);
        spi_bits(8'h20, 8, rx);
        spi_bits(8'h00, 3, rx);
        n_cmp++;
        if (spi_sdo_oe !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midread_active: got oe=%b busy=%b required 1 1", spi_sdo_oe, busy);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({spi_sdo, spi_sdo_oe, reg_we, reg_re, busy} !== 5'b0 || reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin
            n_bad++;
            $display("FAIL midread_reset: got sdo=%b oe=%b we=%b re=%b busy=%b addr=%h wdata=%h required all 0",
                     spi_sdo, spi_sdo_oe, reg_we, reg_re, busy, reg_addr, reg_wdata);
        end
        wait_clk(3);
        resetn = 1'b1;
        wait_clk(10);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midread_csb_low_after_reset: got busy=%b required 0", busy);
        end
        spi_csb = 1'b1;
        wait_clk(4 * HALF);
        tx_data.delete();
        for (int i = 0; i < 3; i++) tx_data.push_back(8'($urandom));
        run(8'h40, 8'h20, 3);
        check_read("post_reset_read");
    endtask

    task automatic test_no_overlap();
        n_cmp++;
        if (overlap !== 0) begin
            n_bad++;
            $display("FAIL strobe_overlap: got %0d clks with we&re required 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_write();
        test_wrap();
        test_abort_illegal();
        test_reset_mid_read();
        test_no_overlap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
